// File: rtl/cmp_sweep_checker.sv
// cmp_sweep_checker: exhaustive self-test sweep engine for a WIDTH-bit
// magnitude comparator. Walks every {a_out, b_out} pair (b fastest), holds each
// pair SETTLE+1 cycles, samples lt/gt/eq at the end of the hold window and
// checks them against the unsigned relation. It reports pass/fail, an error
// count and the first failing pair.
// Optional build macro CMP_SWEEP_STOP_ON_FAIL_EN: when defined, the first
// mismatch ends the sweep and a_out/b_out keep the failing pair.
module cmp_sweep_checker #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  input  logic               lt_in,
  input  logic               gt_in,
  input  logic               eq_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b
);

  localparam int VW = 2 * WIDTH;
  localparam int CW = 2 * WIDTH + 1;
  localparam logic [3:0] HOLD_LAST = 4'(SETTLE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] fail_a_q, fail_a_d, fail_b_q, fail_b_d;
  logic [3:0]       hold_q, hold_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [CW-1:0]    err_q, err_d;

  logic [VW-1:0]    vec_s, vec_inc_s;
  logic [CW-1:0]    err_inc_s;
  logic             mismatch_s, last_vec_s, stop_s;

  // A response is good only when it is exactly the one-hot code of the
  // unsigned relation; none-high and multi-high codes both fail.
  function automatic logic result_ok(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic lt, input logic gt,
                                     input logic eq);
    logic [2:0] want;
    want = {(a < b), (a > b), (a == b)};
    return ({lt, gt, eq} == want);
  endfunction

  assign vec_s      = {a_q, b_q};
  assign vec_inc_s  = vec_s + {{(VW-1){1'b0}}, 1'b1};
  assign mismatch_s = ~result_ok(a_q, b_q, lt_in, gt_in, eq_in);
  assign err_inc_s  = err_q + {{(CW-1){1'b0}}, mismatch_s};
  assign last_vec_s = &vec_s;
`ifdef CMP_SWEEP_STOP_ON_FAIL_EN
  assign stop_s     = last_vec_s | mismatch_s;
`else
  assign stop_s     = last_vec_s;
`endif

  // Next-state and next-output logic of the sweep sequencer.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    hold_d   = hold_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    fail_a_d = fail_a_q;
    fail_b_d = fail_b_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          a_d      = '0;
          b_d      = '0;
          hold_d   = 4'd0;
          busy_d   = 1'b1;
          pass_d   = 1'b0;
          err_d    = '0;
          fail_a_d = '0;
          fail_b_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (hold_q == HOLD_LAST) begin
          // End of the hold window: sample, score, then advance or finish.
          hold_d = 4'd0;
          err_d  = err_inc_s;
          if (mismatch_s && (err_q == '0)) begin
            fail_a_d = a_q;
            fail_b_d = b_q;
          end else begin
            fail_a_d = fail_a_q;
            fail_b_d = fail_b_q;
          end
          if (stop_s) begin
            state_d = ST_FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_inc_s == '0);
          end else begin
            {a_d, b_d} = vec_inc_s;
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      ST_FINISH: begin
        // done is visible for exactly this cycle; start is ignored here.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      hold_q   <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fail_a_q <= '0;
      fail_b_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hold_q   <= hold_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fail_a_q <= fail_a_d;
      fail_b_q <= fail_b_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;

endmodule
